// File: rtl/lane_pkg.sv
// Shared lane constants for the 64B/67B encode/decode pair: header codes,
// bit positions within the lane word, lock FSM states and default thresholds.
package lane_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int INV_BIT = 66;
    localparam int SH_MSB  = 65;
    localparam int SH_LSB  = 64;

    localparam int DEF_LOCK_CNT   = 64;
    localparam int DEF_WIN_LEN    = 64;
    localparam int DEF_ERR_THRESH = 16;
    localparam int DEF_DISP_LIMIT = 96;
    localparam int DEF_SLIP_WAIT  = 4;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_HOLD = 2'd1,
        ST_LOCKED    = 2'd2
    } lock_state_t;

    function automatic logic header_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock state machine: qualifies sync headers, hunts for alignment with
// slip requests to the gearbox and monitors header errors once locked.
module block_lock_fsm
    import lane_pkg::*;
#(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int ERR_THRESH = DEF_ERR_THRESH,
    parameter int SLIP_WAIT  = DEF_SLIP_WAIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bypass,
    input  logic       i_valid,
    input  logic [1:0] i_header,
    output logic       o_block_lock,
    output logic       o_slip,
    output logic       o_header_err,
    output logic       o_hold
);

    localparam int CNT_MAX = (LOCK_CNT > WIN_LEN) ? LOCK_CNT : WIN_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HOLD_W  = $clog2(SLIP_WAIT + 1);

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_good_cnt;
    logic [CNT_W-1:0]  w_good_nxt;
    logic [CNT_W-1:0]  r_win_cnt;
    logic [CNT_W-1:0]  w_win_nxt;
    logic [CNT_W-1:0]  r_bad_cnt;
    logic [CNT_W-1:0]  w_bad_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_slip;
    logic              w_slip_nxt;
    logic              r_header_err;
    logic              w_header_err_nxt;
    logic              w_hdr_ok;
    logic [CNT_W-1:0]  w_win_inc;
    logic [CNT_W-1:0]  w_bad_inc;

    assign w_hdr_ok  = header_valid(i_header);
    assign w_win_inc = r_win_cnt + 1'b1;
    assign w_bad_inc = r_bad_cnt + CNT_W'(!w_hdr_ok);

    always_comb begin
        w_state_nxt      = r_state;
        w_good_nxt       = r_good_cnt;
        w_win_nxt        = r_win_cnt;
        w_bad_nxt        = r_bad_cnt;
        w_hold_nxt       = r_hold_cnt;
        w_slip_nxt       = 1'b0;
        w_header_err_nxt = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                if (i_valid) begin
                    if (!w_hdr_ok) begin
                        w_slip_nxt  = 1'b1;
                        w_good_nxt  = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_SLIP_HOLD;
                    end else if (r_good_cnt == CNT_W'(LOCK_CNT - 1)) begin
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
            end
            ST_SLIP_HOLD: begin
                // Counts raw cycles: the gearbox needs time to settle after a slip.
                if (r_hold_cnt == HOLD_W'(SLIP_WAIT - 1)) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (i_valid) begin
                    w_header_err_nxt = !w_hdr_ok;
                    // Loss of lock takes precedence over a coincident window end.
                    if (!w_hdr_ok && (w_bad_inc == CNT_W'(ERR_THRESH))) begin
                        w_slip_nxt  = 1'b1;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_SLIP_HOLD;
                    end else if (w_win_inc == CNT_W'(WIN_LEN)) begin
                        w_win_nxt = '0;
                        w_bad_nxt = '0;
                    end else begin
                        w_win_nxt = w_win_inc;
                        w_bad_nxt = w_bad_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase

        if (i_bypass) begin
            w_state_nxt      = ST_SEARCH;
            w_good_nxt       = '0;
            w_win_nxt        = '0;
            w_bad_nxt        = '0;
            w_hold_nxt       = '0;
            w_slip_nxt       = 1'b0;
            w_header_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_SEARCH;
            r_good_cnt   <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_slip       <= 1'b0;
            r_header_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_win_cnt    <= w_win_nxt;
            r_bad_cnt    <= w_bad_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_slip       <= w_slip_nxt;
            r_header_err <= w_header_err_nxt;
        end
    end

    assign o_block_lock = (r_state == ST_LOCKED);
    assign o_hold       = (r_state == ST_SLIP_HOLD);
    assign o_slip       = r_slip;
    assign o_header_err = r_header_err;

endmodule

// File: rtl/decode_67b_64b.sv
// Lane 64B/67B receive decoder: undoes payload inversion, extracts the sync
// header, drives block lock / slip and checks running disparity while locked.
module decode_67b_64b
    import lane_pkg::*;
#(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int ERR_THRESH = DEF_ERR_THRESH,
    parameter int DISP_LIMIT = DEF_DISP_LIMIT,
    parameter int SLIP_WAIT  = DEF_SLIP_WAIT
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic        PASSTHROUGH,
    input  logic [79:0] DATA_IN,
    input  logic        DATA_VALID_IN,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_VALID_OUT,
    output logic        BLOCK_LOCK,
    output logic        SLIP,
    output logic        HEADER_ERR,
    output logic        DISP_ERR
);

    localparam logic signed [15:0] DISP_POS = 16'(DISP_LIMIT);
    localparam logic signed [15:0] DISP_NEG = -DISP_POS;

    logic                w_hold;
    logic                w_unused_hi;
    logic [1:0]          w_header;
    logic [63:0]         w_payload;
    logic [63:0]         w_decoded;
    logic signed [7:0]   w_wd;
    logic signed [15:0]  w_rd_sum;
    logic                w_disp_over;
    logic signed [15:0]  r_rd;

    // Word disparity over all 67 received bits: ones minus zeros.
    function automatic logic signed [7:0] word_disp(input logic [66:0] v);
        logic [6:0]        pop;
        logic signed [8:0] d;
        pop = '0;
        for (int i = 0; i < 67; i++) begin
            pop = pop + 7'(v[i]);
        end
        d = $signed({1'b0, pop, 1'b0}) - 9'sd67;
        return d[7:0];
    endfunction

    function automatic logic disp_exceeds(input logic signed [15:0] s);
        return (s > DISP_POS) || (s < DISP_NEG);
    endfunction

    assign w_unused_hi = ^DATA_IN[79:INV_BIT+1];
    assign w_header    = DATA_IN[SH_MSB:SH_LSB];
    assign w_payload   = DATA_IN[SH_LSB-1:0];
    assign w_decoded   = DATA_IN[INV_BIT] ? ~w_payload : w_payload;
    assign w_wd        = word_disp(DATA_IN[INV_BIT:0]);
    assign w_rd_sum    = r_rd + $signed({{8{w_wd[7]}}, w_wd});
    assign w_disp_over = disp_exceeds(w_rd_sum);

    block_lock_fsm #(
        .LOCK_CNT   (LOCK_CNT),
        .WIN_LEN    (WIN_LEN),
        .ERR_THRESH (ERR_THRESH),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_lock (
        .i_clk        (USER_CLK),
        .i_rst        (SYSTEM_RESET),
        .i_bypass     (PASSTHROUGH),
        .i_valid      (DATA_VALID_IN),
        .i_header     (w_header),
        .o_block_lock (BLOCK_LOCK),
        .o_slip       (SLIP),
        .o_header_err (HEADER_ERR),
        .o_hold       (w_hold)
    );

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            DATA_OUT       <= '0;
            HEADER_OUT     <= '0;
            DATA_VALID_OUT <= 1'b0;
            DISP_ERR       <= 1'b0;
            r_rd           <= '0;
        end else if (PASSTHROUGH) begin
            DATA_OUT       <= w_payload;
            HEADER_OUT     <= '0;
            DATA_VALID_OUT <= DATA_VALID_IN;
            DISP_ERR       <= 1'b0;
            r_rd           <= '0;
        end else begin
            DATA_OUT       <= w_decoded;
            HEADER_OUT     <= w_header;
            DATA_VALID_OUT <= DATA_VALID_IN && !w_hold;
            DISP_ERR       <= 1'b0;
            // Outside LOCKED the accumulator sits at zero, so entry starts clean.
            if (!BLOCK_LOCK) begin
                r_rd <= '0;
            end else if (DATA_VALID_IN) begin
                if (w_disp_over) begin
                    DISP_ERR <= 1'b1;
                    r_rd     <= '0;
                end else begin
                    r_rd <= w_rd_sum;
                end
            end
        end
    end

endmodule
